// File: rtl/multi_debouncer.sv
// multi_debouncer: N independent switch debouncers. Each channel synchronises its raw
// input, then a 4-state FSM with a stability counter commits a new debounced level only
// after the synchronised input has differed from it for StableCycles consecutive clocks.
module multi_debouncer #(
   parameter int unsigned NumCh        = 4,
   parameter int unsigned ClkFreq      = 100_000_000,
   parameter int unsigned StableTimeMs = 10,
   parameter int unsigned SyncStages   = 2,
   parameter logic        RstLevel     = 1'b0
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic [NumCh-1:0] en_i,
   input  logic [NumCh-1:0] sw_i,
   output logic [NumCh-1:0] db_level_o,
   output logic [NumCh-1:0] db_rise_o,
   output logic [NumCh-1:0] db_fall_o,
   output logic             any_tick_o
);

   localparam int unsigned StableCycles = ClkFreq / 1000 * StableTimeMs;
   localparam int unsigned CntW         = $clog2(StableCycles);

   // Last count value before a commit; the count starts at 1 on entering a wait state.
   localparam logic [CntW-1:0] CntLast = CntW'(StableCycles - 1);
   localparam logic [CntW-1:0] CntOne  = CntW'(1);

   typedef enum logic [1:0] {
      StStableLo,
      StWaitHi,
      StStableHi,
      StWaitLo
   } state_e;

   localparam state_e StReset = RstLevel ? StStableHi : StStableLo;

   for (genvar k = 0; k < NumCh; k++) begin : g_ch
      logic [SyncStages-1:0] sync_q;
      logic                  s;
      state_e                state_q;
      logic [CntW-1:0]       cnt_q;
      logic                  level_q;
      logic                  rise_q;
      logic                  fall_q;

      assign s = sync_q[SyncStages-1];

      // Synchroniser shift chain; keeps running even while the channel is disabled.
      always_ff @(posedge clk_i or negedge rst_ni) begin
         if (!rst_ni) begin
            sync_q <= {SyncStages{RstLevel}};
         end else begin
            sync_q <= {sync_q[SyncStages-2:0], sw_i[k]};
         end
      end

      // Debounce FSM with stability counter and registered level/tick outputs.
      always_ff @(posedge clk_i or negedge rst_ni) begin
         if (!rst_ni) begin
            state_q <= StReset;
            cnt_q   <= '0;
            level_q <= RstLevel;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
         end else begin
            rise_q <= 1'b0;
            fall_q <= 1'b0;
            if (!en_i[k]) begin
               // Park in the stable state matching the frozen level so that
               // re-enabling always starts a fresh full count.
               state_q <= level_q ? StStableHi : StStableLo;
               cnt_q   <= '0;
            end else begin
               unique case (state_q)
                  StStableLo: begin
                     if (s) begin
                        state_q <= StWaitHi;
                        cnt_q   <= CntOne;
                     end else begin
                        cnt_q <= '0;
                     end
                  end
                  StWaitHi: begin
                     if (!s) begin
                        state_q <= StStableLo;
                        cnt_q   <= '0;
                     end else if (cnt_q == CntLast) begin
                        state_q <= StStableHi;
                        cnt_q   <= '0;
                        level_q <= 1'b1;
                        rise_q  <= 1'b1;
                     end else begin
                        cnt_q <= cnt_q + CntOne;
                     end
                  end
                  StStableHi: begin
                     if (!s) begin
                        state_q <= StWaitLo;
                        cnt_q   <= CntOne;
                     end else begin
                        cnt_q <= '0;
                     end
                  end
                  StWaitLo: begin
                     if (s) begin
                        state_q <= StStableHi;
                        cnt_q   <= '0;
                     end else if (cnt_q == CntLast) begin
                        state_q <= StStableLo;
                        cnt_q   <= '0;
                        level_q <= 1'b0;
                        fall_q  <= 1'b1;
                     end else begin
                        cnt_q <= cnt_q + CntOne;
                     end
                  end
                  default: begin
                     state_q <= StReset;
                     cnt_q   <= '0;
                  end
               endcase
            end
         end
      end

      assign db_level_o[k] = level_q;
      assign db_rise_o[k]  = rise_q;
      assign db_fall_o[k]  = fall_q;
   end

   assign any_tick_o = |(db_rise_o | db_fall_o);

endmodule

// File: tb/tb_multi_debouncer.sv
// tb_multi_debouncer: directed stimulus against a cycle-level behavioural model of the
// debouncer (input history + run-length of disagreement per channel), compared every
// cycle, plus literal checks of latency, glitch rejection, enable and reset behaviour.
module tb_multi_debouncer;

   localparam int   NumCh        = 4;
   localparam int   SyncStages   = 2;
   localparam int   StableCycles = 10;
   localparam logic RstLevel     = 1'b0;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic [NumCh-1:0] en = '1;
   logic [NumCh-1:0] sw = '0;
   logic [NumCh-1:0] db_level, db_rise, db_fall;
   logic             any_tick;

   int nvec = 0;
   int nerr = 0;

   always #5 clk = ~clk;

   multi_debouncer #(
      .NumCh        (NumCh),
      .ClkFreq      (10_000),
      .StableTimeMs (1),
      .SyncStages   (SyncStages),
      .RstLevel     (RstLevel)
   ) dut (
      .clk_i      (clk),
      .rst_ni     (rst_n),
      .en_i       (en),
      .sw_i       (sw),
      .db_level_o (db_level),
      .db_rise_o  (db_rise),
      .db_fall_o  (db_fall),
      .any_tick_o (any_tick)
   );

   // Model state: hist[i] is the sw sample taken i+1 clocks ago; run[k] counts
   // consecutive clocks in which the delayed input disagreed with the level.
   logic [NumCh-1:0] m_level, m_rise, m_fall;
   logic [NumCh-1:0] hist [SyncStages];
   int               run  [NumCh];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Behavioural model, evaluated on every rising edge.
   initial begin
      logic [NumCh-1:0] seen;
      m_level = {NumCh{RstLevel}};
      m_rise  = '0;
      m_fall  = '0;
      for (int i = 0; i < SyncStages; i++) hist[i] = {NumCh{RstLevel}};
      for (int k = 0; k < NumCh; k++) run[k] = 0;
      forever begin
         @(posedge clk);
         if (!rst_n) begin
            m_level = {NumCh{RstLevel}};
            m_rise  = '0;
            m_fall  = '0;
            for (int i = 0; i < SyncStages; i++) hist[i] = {NumCh{RstLevel}};
            for (int k = 0; k < NumCh; k++) run[k] = 0;
         end else begin
            seen = hist[SyncStages-1];
            for (int i = SyncStages - 1; i > 0; i--) hist[i] = hist[i-1];
            hist[0] = sw;
            m_rise = '0;
            m_fall = '0;
            for (int k = 0; k < NumCh; k++) begin
               if (!en[k]) begin
                  run[k] = 0;
               end else if (seen[k] != m_level[k]) begin
                  run[k]++;
                  if (run[k] == StableCycles) begin
                     m_level[k] = seen[k];
                     m_rise[k]  = seen[k];
                     m_fall[k]  = !seen[k];
                     run[k]     = 0;
                  end
               end else begin
                  run[k] = 0;
               end
            end
         end
      end
   end

   // Compare DUT against model on every falling edge outside reset.
   initial begin
      forever begin
         @(negedge clk);
         if (rst_n) begin
            chk("level", 32'(db_level), 32'(m_level));
            chk("rise", 32'(db_rise), 32'(m_rise));
            chk("fall", 32'(db_fall), 32'(m_fall));
            chk("any_tick", 32'(any_tick), 32'(|(m_rise | m_fall)));
            chk("rise_fall_overlap", 32'(db_rise & db_fall), 32'd0);
         end
      end
   end

   // Stimulus was just applied; the commit must land on edge 'lat' and last one cycle.
   task automatic expect_edge(input int ch, input bit rising, input int lat);
      for (int k = 1; k <= lat + 1; k++) begin
         step();
         if (k == lat - 1) begin
            chk("pre_commit_level", 32'(db_level[ch]), 32'(!rising));
            chk("pre_commit_any", 32'(any_tick), 32'd0);
         end else if (k == lat) begin
            chk("commit_level", 32'(db_level[ch]), 32'(rising));
            chk("commit_tick", 32'(rising ? db_rise[ch] : db_fall[ch]), 32'd1);
            chk("commit_any", 32'(any_tick), 32'd1);
         end else if (k == lat + 1) begin
            chk("tick_width", 32'(db_rise[ch] | db_fall[ch]), 32'd0);
            chk("hold_level", 32'(db_level[ch]), 32'(rising));
         end
      end
   endtask

   initial begin
      // Reset state
      repeat (3) step();
      chk("reset_level", 32'(db_level), 32'h0);
      chk("reset_ticks", 32'({db_rise, db_fall, any_tick}), 32'h0);
      rst_n = 1'b1;

      // 1. Idle after reset
      repeat (50) step();
      chk("idle_level", 32'(db_level), 32'h0);

      // 2. Clean rise on channel 0: 12 clocks of latency
      sw[0] = 1'b1;
      expect_edge(0, 1'b1, 12);
      repeat (3) step();

      // 3. Nine-cycle glitch rejected, then a held level commits
      sw[1] = 1'b1;
      repeat (9) step();
      sw[1] = 1'b0;
      repeat (20) step();
      chk("glitch_level", 32'(db_level[1]), 32'd0);
      sw[1] = 1'b1;
      expect_edge(1, 1'b1, 12);
      repeat (3) step();

      // 4. Channel 2 rise then release
      sw[2] = 1'b1;
      expect_edge(2, 1'b1, 12);
      sw[2] = 1'b0;
      expect_edge(2, 1'b0, 12);
      repeat (3) step();

      // 5. Channels 3 and 2 rise together
      sw[3:2] = 2'b11;
      repeat (11) step();
      chk("pair_pre", 32'(db_rise), 32'h0);
      step();
      chk("pair_rise", 32'(db_rise), 32'hC);
      chk("pair_any", 32'(any_tick), 32'd1);
      step();
      chk("pair_any_width", 32'(any_tick), 32'd0);
      chk("pair_level", 32'(db_level), 32'hF);

      // 6a. Disable mid-count, then re-enable: fresh 10-cycle count
      sw[0] = 1'b0;
      repeat (5) step();
      en[0] = 1'b0;
      repeat (20) step();
      chk("disabled_level", 32'(db_level[0]), 32'd1);
      en[0] = 1'b1;
      expect_edge(0, 1'b0, 10);
      repeat (3) step();

      // 6b. Reset mid-count on channel 1: no tick, level back to reset value
      sw[1] = 1'b0;
      repeat (5) step();
      rst_n = 1'b0;
      step();
      chk("midrst_level", 32'(db_level), 32'h0);
      chk("midrst_ticks", 32'({db_rise, db_fall}), 32'h0);
      step();
      rst_n = 1'b1;
      repeat (11) step();
      chk("post_rst_quiet", 32'({db_rise, db_fall}), 32'h0);
      step();
      chk("post_rst_rise", 32'(db_rise), 32'hC);
      repeat (20) step();
      chk("post_rst_level", 32'(db_level), 32'hC);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
